// File: rtl/mips_cpu_ctrl_slave.sv
// mips_cpu_ctrl_slave: AXI4-Lite control window for the MIPS core (RUN bit, cycle/retire counters, scratch).
// Revision: 1.0
`default_nettype none

module mips_cpu_ctrl_slave #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  mips_cpu_clk,
  input  logic                  mips_cpu_reset,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  input  logic                  cpu_inst_retire,
  output logic                  cpu_reset
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_CYCLE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_INST    = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(3);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

  w_state_e            w_state_q;
  r_state_e            r_state_q;
  logic                run_q, run_d;
  logic [DATA_W-1:0]   cyc_q, cyc_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic [DATA_W-1:0]   scratch_q, scratch_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [IDX_W-1:0]    w_idx, r_idx;
  logic                wr_fire, rd_fire;
  logic                unused_addr_lsbs;

  assign w_idx   = s_awaddr[ADDR_W-1:2];
  assign r_idx   = s_araddr[ADDR_W-1:2];
  assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  // Address and data are only taken together, so neither channel is ever half-accepted.
  assign wr_fire   = (w_state_q == W_IDLE) & s_awvalid & s_wvalid;
  assign rd_fire   = (r_state_q == R_IDLE) & s_arvalid;
  assign s_awready = wr_fire;
  assign s_wready  = wr_fire;
  assign s_bvalid  = (w_state_q == W_RESP);
  assign s_bresp   = bresp_q;
  assign s_arready = (r_state_q == R_IDLE);
  assign s_rvalid  = (r_state_q == R_RESP);
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign cpu_reset = mips_cpu_reset | ~run_q;

  always_comb begin
    run_d     = run_q;
    scratch_d = scratch_q;
    bresp_d   = bresp_q;
    if (wr_fire) begin
      bresp_d = RESP_OKAY;
      case (w_idx)
        IDX_CTRL:    if (s_wstrb[0]) run_d = s_wdata[0];
        IDX_CYCLE,
        IDX_INST:    ;
        IDX_SCRATCH: begin
          for (int b = 0; b < DATA_W/8; b++) begin
            if (s_wstrb[b]) scratch_d[8*b +: 8] = s_wdata[8*b +: 8];
          end
        end
        default:     bresp_d = RESP_SLVERR;
      endcase
    end
  end

  // A RUN rising edge restarts both counters; that clear takes priority over counting.
  always_comb begin
    cyc_d  = cyc_q;
    inst_d = inst_q;
    if (run_d & ~run_q) begin
      cyc_d  = '0;
      inst_d = '0;
    end else if (run_q) begin
      cyc_d = cyc_q + 1'b1;
      if (cpu_inst_retire) inst_d = inst_q + 1'b1;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (rd_fire) begin
      rresp_d = RESP_OKAY;
      case (r_idx)
        IDX_CTRL:    rdata_d = {{(DATA_W-1){1'b0}}, run_q};
        IDX_CYCLE:   rdata_d = cyc_q;
        IDX_INST:    rdata_d = inst_q;
        IDX_SCRATCH: rdata_d = scratch_q;
        default: begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end
  end

  always_ff @(posedge mips_cpu_clk) begin
    if (mips_cpu_reset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      run_q     <= 1'b0;
      cyc_q     <= '0;
      inst_q    <= '0;
      scratch_q <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      run_q     <= run_d;
      cyc_q     <= cyc_d;
      inst_q    <= inst_d;
      scratch_q <= scratch_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      case (w_state_q)
        W_IDLE:  if (wr_fire)  w_state_q <= W_RESP;
        default: if (s_bready) w_state_q <= W_IDLE;
      endcase
      case (r_state_q)
        R_IDLE:  if (rd_fire)  r_state_q <= R_RESP;
        default: if (s_rready) r_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_ctrl_slave.sv
// tb_mips_cpu_ctrl_slave: directed self-checking bench for the CPU control window.
`default_nettype none

module tb_mips_cpu_ctrl_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [11:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic        retire;
  logic        cpu_reset;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_cpu_ctrl_slave #(.ADDR_W(12), .DATA_W(32)) dut (
    .mips_cpu_clk    (clk),
    .mips_cpu_reset  (rst),
    .s_awaddr        (s_awaddr),
    .s_awvalid       (s_awvalid),
    .s_awready       (s_awready),
    .s_wdata         (s_wdata),
    .s_wstrb         (s_wstrb),
    .s_wvalid        (s_wvalid),
    .s_wready        (s_wready),
    .s_bresp         (s_bresp),
    .s_bvalid        (s_bvalid),
    .s_bready        (s_bready),
    .s_araddr        (s_araddr),
    .s_arvalid       (s_arvalid),
    .s_arready       (s_arready),
    .s_rdata         (s_rdata),
    .s_rresp         (s_rresp),
    .s_rvalid        (s_rvalid),
    .s_rready        (s_rready),
    .cpu_inst_retire (retire),
    .cpu_reset       (cpu_reset)
  );

  // Called at posedge+1; returns at posedge+1 after the B handshake.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] resp, output logic ok);
    s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1'b1; s_wvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (s_awready && s_wready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (!s_bvalid) ok = 1'b0;
    resp = s_bresp;
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output logic ok);
    s_araddr = a; s_arvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (s_arready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    if (!s_rvalid) ok = 1'b0;
    d = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; logic ok;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({s_arready, s_bvalid, s_rvalid, cpu_reset} !== 4'b1001) begin
      errors++; $display("FAIL reset_flags got %b exp 1001", {s_arready, s_bvalid, s_rvalid, cpu_reset});
    end
    checks++;
    if ({s_bresp, s_rresp, s_rdata} !== 36'h0) begin
      errors++; $display("FAIL reset_outs got %h exp 0", {s_bresp, s_rresp, s_rdata});
    end
    axi_read(12'h000, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl got ok=%b d=%h r=%b exp ok=1 d=0 r=00", ok, d, r);
    end
    axi_read(12'h004, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL reset_cycle got ok=%b d=%h r=%b exp ok=1 d=0 r=00", ok, d, r);
    end
  endtask

  task automatic test_ro_write();
    logic [31:0] d; logic [1:0] r; logic ok;
    axi_write(12'h004, 32'h1234, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b00) begin
      errors++; $display("FAIL ro_wr_resp got ok=%b r=%b exp ok=1 r=00", ok, r);
    end
    axi_read(12'h004, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0) begin
      errors++; $display("FAIL ro_wr_cycle got ok=%b d=%h exp d=0", ok, d);
    end
  endtask

  task automatic test_ctrl_strobe();
    logic [31:0] d; logic [1:0] r; logic ok;
    axi_write(12'h000, 32'hFFFF_FFFF, 4'b1110, r, ok);
    checks++;
    if (!ok || r !== 2'b00 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL ctrl_nostrb got ok=%b r=%b cpu_reset=%b exp 1 00 1", ok, r, cpu_reset);
    end
    axi_read(12'h000, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0) begin
      errors++; $display("FAIL ctrl_nostrb_rd got %h exp 0", d);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d; logic [1:0] r; logic ok;
    axi_write(12'h00C, 32'hDEAD_BEEF, 4'b0101, r, ok);
    checks++;
    if (!ok || r !== 2'b00) begin
      errors++; $display("FAIL scratch_resp got ok=%b r=%b exp 1 00", ok, r);
    end
    axi_read(12'h00C, d, r, ok);
    checks++;
    if (!ok || d !== 32'h00AD_00EF) begin
      errors++; $display("FAIL scratch_strb got %h exp 00ad00ef", d);
    end
    axi_write(12'h00E, 32'h5A00_0000, 4'b1000, r, ok);
    axi_read(12'h00D, d, r, ok);
    checks++;
    if (!ok || d !== 32'h5AAD_00EF) begin
      errors++; $display("FAIL scratch_lsbs got %h exp 5aad00ef", d);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] r; logic ok;
    axi_write(12'h010, 32'hFFFF_FFFF, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b10) begin
      errors++; $display("FAIL slverr_wr got ok=%b r=%b exp 1 10", ok, r);
    end
    axi_read(12'h010, d, r, ok);
    checks++;
    if (!ok || r !== 2'b10 || d !== 32'h0) begin
      errors++; $display("FAIL slverr_rd got r=%b d=%h exp 10 0", r, d);
    end
    s_awaddr = 12'h00C; s_awvalid = 1'b1; s_wdata = 32'h0; s_wstrb = 4'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_awready !== 1'b0 || s_wready !== 1'b0) begin
        errors++; $display("FAIL aw_alone cyc %0d got awready=%b wready=%b exp 0 0", i, s_awready, s_wready);
      end
      @(posedge clk); #1;
    end
    s_wvalid = 1'b1; #1;
    checks++;
    if (s_awready !== 1'b1 || s_wready !== 1'b1) begin
      errors++; $display("FAIL aw_with_w got awready=%b wready=%b exp 1 1", s_awready, s_wready);
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic test_run_counters();
    logic [31:0] d; logic [1:0] r; logic ok;
    axi_write(12'h000, 32'h1, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b00 || cpu_reset !== 1'b0) begin
      errors++; $display("FAIL run_set got ok=%b r=%b cpu_reset=%b exp 1 00 0", ok, r, cpu_reset);
    end
    repeat (10) @(posedge clk);
    #1;
    axi_read(12'h004, d, r, ok);
    checks++;
    if (!ok || d < 32'd10 || d > 32'd13) begin
      errors++; $display("FAIL cycle_10 got %0d exp 10..13", d);
    end
    axi_write(12'h000, 32'h0, 4'hF, r, ok);
    axi_write(12'h000, 32'h1, 4'hF, r, ok);
    axi_read(12'h004, d, r, ok);
    checks++;
    if (!ok || d > 32'd3) begin
      errors++; $display("FAIL cycle_clear got %0d exp 0..3", d);
    end
  endtask

  task automatic test_retire();
    logic [31:0] d; logic [1:0] r; logic ok;
    retire = 1'b1;
    repeat (5) @(posedge clk);
    #1 retire = 1'b0;
    axi_read(12'h008, d, r, ok);
    checks++;
    if (!ok || d !== 32'd5) begin
      errors++; $display("FAIL inst_5 got %0d exp 5", d);
    end
    axi_write(12'h000, 32'h0, 4'hF, r, ok);
    retire = 1'b1;
    repeat (3) @(posedge clk);
    #1 retire = 1'b0;
    axi_read(12'h008, d, r, ok);
    checks++;
    if (!ok || d !== 32'd5) begin
      errors++; $display("FAIL inst_frozen got %0d exp 5", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; logic ok;
    axi_write(12'h00C, 32'h1122_3344, 4'hF, r, ok);
    s_awaddr = 12'h00C; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; #1;
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || s_awready !== 1'b0) begin
        errors++; $display("FAIL b_stall cyc %0d got bvalid=%b bresp=%b exp 1 00", i, s_bvalid, s_bresp);
      end
      @(posedge clk); #1;
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    checks++;
    if (s_bvalid !== 1'b0) begin
      errors++; $display("FAIL b_release got bvalid=%b exp 0", s_bvalid);
    end
    s_araddr = 12'h00C; s_arvalid = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFE_F00D || s_rresp !== 2'b00 || s_arready !== 1'b0) begin
        errors++; $display("FAIL r_stall cyc %0d got rvalid=%b rdata=%h exp 1 cafef00d", i, s_rvalid, s_rdata);
      end
      @(posedge clk); #1;
    end
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; logic ok;
    axi_write(12'h000, 32'h1, 4'hF, r, ok);
    s_araddr = 12'h000; s_arvalid = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    checks++;
    if (s_rvalid !== 1'b1 || cpu_reset !== 1'b0) begin
      errors++; $display("FAIL mid_pre got rvalid=%b cpu_reset=%b exp 1 0", s_rvalid, cpu_reset);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (s_rvalid !== 1'b0 || cpu_reset !== 1'b1 || s_arready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got rvalid=%b cpu_reset=%b arready=%b exp 0 1 1", s_rvalid, cpu_reset, s_arready);
    end
    axi_read(12'h000, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0) begin
      errors++; $display("FAIL mid_run got %h exp 0", d);
    end
    axi_read(12'h00C, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0) begin
      errors++; $display("FAIL mid_scratch got %h exp 0", d);
    end
  endtask

  initial begin
    rst = 1'b1; s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0; retire = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_ro_write();
    test_ctrl_strobe();
    test_scratch();
    test_slverr();
    test_run_counters();
    test_retire();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
